pause_dim: RTL and testbench
============================

PAUSE_DIM -- requirements
Module: pause_dim

Interface
REQ-001 SHALL have parameter RW, default 3: red channel width in bits (1..8).
REQ-002 SHALL have parameter GW, default 3: green channel width in bits (1..8).
REQ-003 SHALL have parameter BW, default 2: blue channel width in bits (1..8).
REQ-004 SHALL have parameter NSRC, default 2: number of external pause sources (1..8).
REQ-005 SHALL have parameter DIM_TIMEOUT, default 32'hE4E1C00: cycles of user pause before first dim step (>=1).
REQ-006 SHALL have parameter FADE_STEPS, default 1: maximum dim level, i.e. maximum right-shift (1..3).
REQ-007 SHALL have parameter FADE_INTERVAL, default 24000000: cycles between successive dim steps (>=1).
REQ-008 SHALL have port clk_sys, input, 1: the single clock; all logic on its rising edge.
REQ-009 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-010 SHALL have port pause_btn, input, 1: user pause button level, active-high.
REQ-011 SHALL have port wake, input, 1: activity pulse that clears the dim state without unpausing.
REQ-012 SHALL have port ext_pause, input, NSRC: external pause requests (hiscore access, OSD), active-high.
REQ-013 SHALL have port r_in/g_in/b_in, input, RW/GW/BW: pixel colour.
REQ-014 SHALL have port hs_in, vs_in, hblank_in, vblank_in, input, 1 each: video timing.
REQ-015 SHALL have port pause, output, 1: registered core pause.
REQ-016 SHALL have port user_paused, output, 1: user toggle state.
REQ-017 SHALL have port dim_level, output, 2: current shift amount.
REQ-018 SHALL have port r_out/g_out/b_out, output, RW/GW/BW: dimmed colour.
REQ-019 SHALL have port hs_out, vs_out, hblank_out, vblank_out, output, 1 each: timing delayed to match colour.

Function
REQ-020 SHALL register pause_btn into btn_prev each cycle; rising edge = pause_btn & ~btn_prev.
REQ-021 SHALL invert user_paused on each rising edge, effective next cycle.
REQ-022 SHALL drive pause <= next user_paused | (|ext_pause), i.e. 1-cycle latency from either the button edge or ext_pause.
REQ-023 SHALL not let ext_pause affect the timer or dim_level.
REQ-024 SHALL run a timer that increments while user_paused=1 and timer<DIM_TIMEOUT, saturating at DIM_TIMEOUT.
REQ-025 SHALL clear timer, fade counter and dim_level to 0 in the cycle after user_paused becomes 0.
REQ-026 SHALL set dim_level to 1 on the edge where the timer reaches DIM_TIMEOUT.
REQ-027 SHALL, while 1<=dim_level<FADE_STEPS, run a fade counter 0..FADE_INTERVAL-1 and increment dim_level on its wrap.
REQ-028 SHALL hold dim_level and freeze the fade counter at dim_level=FADE_STEPS.
REQ-029 SHALL, on wake=1 with no button edge, clear timer, fade counter and dim_level to 0; user_paused is unchanged and the timer restarts next cycle if paused.
REQ-030 SHALL give a button edge priority over a simultaneous wake; resulting state follows REQ-021/REQ-025.
REQ-031 SHALL register colour outputs as each channel logically right-shifted by the dim_level value of the same cycle (zero-fill), with 1-cycle latency.
REQ-032 SHALL delay the four timing signals by exactly 1 cycle, never dimmed or gated.

Reset
REQ-033 SHALL, when reset_n=0 at a clock edge, set pause=0, user_paused=0, dim_level=0, timer=0, fade counter=0, all colour and timing outputs=0.
REQ-034 SHALL set btn_prev=1 during reset so a button held through reset release does not toggle.
REQ-035 SHALL abort any count in progress on reset; no state survives it.

Verification (DIM_TIMEOUT=10, FADE_STEPS=2, FADE_INTERVAL=4, RW=GW=3, BW=2)
REQ-036 SHALL cover: pause_btn 0->1 held 20 cycles -> user_paused=1 and pause=1 one cycle after edge, single toggle only; second rising edge -> both 0.
REQ-037 SHALL cover: user pause set, r_in=7,g_in=6,b_in=3 -> dim_level=1 after 10 cycles, outputs 3/3/1 next cycle; dim_level=2 four cycles later, outputs 1/1/0; stays 2 thereafter.
REQ-038 SHALL cover: dim_level=2, wake pulse -> dim_level=0, user_paused=1; dim_level=1 again 10 cycles later.
REQ-039 SHALL cover: ext_pause=2'b01 for 5 cycles, no button -> pause=1 for exactly those 5 cycles delayed 1, dim_level stays 0.
REQ-040 SHALL cover: reset_n=0 for 1 cycle at dim_level=2 with pause_btn held -> all outputs 0; after release with button still held, no toggle.
REQ-041 SHALL cover: button edge and wake in the same cycle while paused at dim_level=1 -> user_paused=0, dim_level=0, pause=0.

Source files
------------

// File: rtl/pause_dim.sv
// pause_dim: user/external pause control with idle screen dimming.
//
// A rising edge on pause_btn toggles the user pause state. The core pause
// output is the user state OR any external pause request, registered.
// After DIM_TIMEOUT cycles of user pause the picture is dimmed one step
// (colour channels shifted right by one), then one further step every
// FADE_INTERVAL cycles up to FADE_STEPS. A wake pulse restores full
// brightness without leaving pause. Video timing is delayed by one cycle to
// stay aligned with the registered colour path.
//
// Ports:
//   clk_sys                    single clock, rising edge
//   reset_n                    synchronous active-low reset
//   pause_btn                  user pause button level
//   wake                       activity pulse, clears dimming
//   ext_pause[NSRC-1:0]        external pause requests
//   r_in/g_in/b_in             pixel colour in
//   hs_in/vs_in/hblank_in/vblank_in  video timing in
//   pause                      registered core pause
//   user_paused                user toggle state
//   dim_level[1:0]             current right-shift amount
//   r_out/g_out/b_out          dimmed colour, 1-cycle latency
//   hs_out/vs_out/hblank_out/vblank_out  timing, 1-cycle latency
module pause_dim #(
  parameter int          RW            = 3,
  parameter int          GW            = 3,
  parameter int          BW            = 2,
  parameter int          NSRC          = 2,
  parameter int unsigned DIM_TIMEOUT   = 32'hE4E1C00,
  parameter int          FADE_STEPS    = 1,
  parameter int unsigned FADE_INTERVAL = 24000000
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            pause_btn,
  input  logic            wake,
  input  logic [NSRC-1:0] ext_pause,
  input  logic [RW-1:0]   r_in,
  input  logic [GW-1:0]   g_in,
  input  logic [BW-1:0]   b_in,
  input  logic            hs_in,
  input  logic            vs_in,
  input  logic            hblank_in,
  input  logic            vblank_in,
  output logic            pause,
  output logic            user_paused,
  output logic [1:0]      dim_level,
  output logic [RW-1:0]   r_out,
  output logic [GW-1:0]   g_out,
  output logic [BW-1:0]   b_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic            hblank_out,
  output logic            vblank_out
);

  localparam logic [31:0] TIMEOUT      = 32'(DIM_TIMEOUT);
  localparam logic [31:0] TIMEOUT_LAST = 32'(DIM_TIMEOUT - 32'd1);
  localparam logic [31:0] FADE_LAST    = 32'(FADE_INTERVAL - 32'd1);
  localparam logic [1:0]  MAX_DIM      = 2'(FADE_STEPS);

  logic          btn_prev_q, btn_prev_d;
  logic          user_paused_q, user_paused_d;
  logic          pause_q, pause_d;
  logic [31:0]   timer_q, timer_d;
  logic [31:0]   fade_q, fade_d;
  logic [1:0]    dim_q, dim_d;
  logic [RW-1:0] r_q, r_d;
  logic [GW-1:0] g_q, g_d;
  logic [BW-1:0] b_q, b_d;
  logic [3:0]    timing_q, timing_d;
  logic          btn_rise;

  always_comb begin
    btn_rise      = pause_btn & ~btn_prev_q;
    btn_prev_d    = pause_btn;
    user_paused_d = user_paused_q ^ btn_rise;
    // Core pause follows the post-toggle user state so it changes on the
    // same edge as user_paused.
    pause_d       = user_paused_d | (|ext_pause);

    timer_d = timer_q;
    fade_d  = fade_q;
    dim_d   = dim_q;

    // Not paused, or woken without a competing button edge: full brightness
    // and restart the idle timer. A button edge beats wake, so an unpause
    // edge lets this cycle proceed and the clear follows once user_paused
    // has dropped.
    if (!user_paused_q || (wake && !btn_rise)) begin
      timer_d = '0;
      fade_d  = '0;
      dim_d   = '0;
    end else begin
      if (timer_q < TIMEOUT) begin
        timer_d = timer_q + 32'd1;
        if (timer_q == TIMEOUT_LAST) begin
          dim_d = 2'd1;
        end
      end
      // dim_level is non-zero only once the timer has saturated, so this
      // never collides with the first-step assignment above.
      if (dim_q != 2'd0 && dim_q < MAX_DIM) begin
        if (fade_q == FADE_LAST) begin
          fade_d = '0;
          dim_d  = dim_q + 2'd1;
        end else begin
          fade_d = fade_q + 32'd1;
        end
      end
    end

    r_d      = r_in >> dim_q;
    g_d      = g_in >> dim_q;
    b_d      = b_in >> dim_q;
    timing_d = {hs_in, vs_in, hblank_in, vblank_in};
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      // Button treated as already pressed so a hold through reset is no edge.
      btn_prev_q    <= 1'b1;
      user_paused_q <= 1'b0;
      pause_q       <= 1'b0;
      timer_q       <= '0;
      fade_q        <= '0;
      dim_q         <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      timing_q      <= '0;
    end else begin
      btn_prev_q    <= btn_prev_d;
      user_paused_q <= user_paused_d;
      pause_q       <= pause_d;
      timer_q       <= timer_d;
      fade_q        <= fade_d;
      dim_q         <= dim_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      timing_q      <= timing_d;
    end
  end

  assign pause       = pause_q;
  assign user_paused = user_paused_q;
  assign dim_level   = dim_q;
  assign r_out       = r_q;
  assign g_out       = g_q;
  assign b_out       = b_q;
  assign hs_out      = timing_q[3];
  assign vs_out      = timing_q[2];
  assign hblank_out  = timing_q[1];
  assign vblank_out  = timing_q[0];

endmodule

// File: tb/tb_pause_dim.sv
// Self-checking bench for pause_dim: directed scenarios followed by random
// stimulus, every cycle compared against a reference model that derives the
// dim level from the number of paused cycles since the last clear.
module tb_pause_dim;

  localparam int RW = 3, GW = 3, BW = 2, NSRC = 2;
  localparam int DT = 10, FS = 2, FI = 4;

  logic            clk_sys = 1'b0;
  logic            reset_n = 1'b0;
  logic            pause_btn = 1'b0;
  logic            wake = 1'b0;
  logic [NSRC-1:0] ext_pause = '0;
  logic [RW-1:0]   r_in = '0;
  logic [GW-1:0]   g_in = '0;
  logic [BW-1:0]   b_in = '0;
  logic            hs_in = 1'b0, vs_in = 1'b0, hblank_in = 1'b0, vblank_in = 1'b0;
  logic            pause, user_paused;
  logic [1:0]      dim_level;
  logic [RW-1:0]   r_out;
  logic [GW-1:0]   g_out;
  logic [BW-1:0]   b_out;
  logic            hs_out, vs_out, hblank_out, vblank_out;

  pause_dim #(
    .RW(RW), .GW(GW), .BW(BW), .NSRC(NSRC),
    .DIM_TIMEOUT(DT), .FADE_STEPS(FS), .FADE_INTERVAL(FI)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .pause_btn(pause_btn), .wake(wake),
    .ext_pause(ext_pause), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
    .pause(pause), .user_paused(user_paused), .dim_level(dim_level),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hs_out(hs_out), .vs_out(vs_out), .hblank_out(hblank_out), .vblank_out(vblank_out)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state
  bit m_btn_prev = 1'b1;
  bit m_up       = 1'b0;
  bit m_pause    = 1'b0;
  int m_paused_cycles = 0;  // paused cycles since last clear
  int m_dim = 0;
  int m_r = 0, m_g = 0, m_b = 0;
  int m_timing = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
  endtask

  function automatic int dim_of(input int elapsed);
    int d;
    if (elapsed < DT) return 0;
    d = 1 + (elapsed - DT) / FI;
    return (d > FS) ? FS : d;
  endfunction

  task automatic model_step();
    int old_dim;
    bit rise;
    old_dim = m_dim;
    if (!reset_n) begin
      m_btn_prev = 1'b1; m_up = 1'b0; m_pause = 1'b0;
      m_paused_cycles = 0; m_dim = 0;
      m_r = 0; m_g = 0; m_b = 0; m_timing = 0;
    end else begin
      rise = pause_btn && !m_btn_prev;
      if (!m_up || (wake && !rise)) m_paused_cycles = 0;
      else if (m_paused_cycles < 1000000) m_paused_cycles++;
      m_up       = m_up ^ rise;
      m_btn_prev = pause_btn;
      m_pause    = m_up || (ext_pause != 0);
      m_dim      = dim_of(m_paused_cycles);
      m_r = int'(r_in) >> old_dim;
      m_g = int'(g_in) >> old_dim;
      m_b = int'(b_in) >> old_dim;
      m_timing = {28'd0, hs_in, vs_in, hblank_in, vblank_in};
    end
  endtask

  // One clock: update the model with the inputs present at the edge, then
  // compare every output shortly after the edge.
  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
    cyc++;
    chk("pause",       32'(pause),       32'(m_pause));
    chk("user_paused", 32'(user_paused), 32'(m_up));
    chk("dim_level",   32'(dim_level),   32'(m_dim));
    chk("r_out",       32'(r_out),       32'(m_r));
    chk("g_out",       32'(g_out),       32'(m_g));
    chk("b_out",       32'(b_out),       32'(m_b));
    chk("timing",      32'({hs_out, vs_out, hblank_out, vblank_out}), 32'(m_timing));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset
    reset_n = 1'b0;
    ticks(3);
    chk("rst_pause", 32'(pause), 32'd0);
    chk("rst_dim",   32'(dim_level), 32'd0);
    reset_n = 1'b1;
    ticks(2);

    // Button held 20 cycles: single toggle
    pause_btn = 1'b1;
    tick();
    chk("btn_up", 32'(user_paused), 32'd1);
    chk("btn_pause", 32'(pause), 32'd1);
    ticks(19);
    chk("btn_hold_up", 32'(user_paused), 32'd1);
    pause_btn = 1'b0; ticks(2);
    pause_btn = 1'b1; tick();
    chk("btn2_up", 32'(user_paused), 32'd0);
    chk("btn2_pause", 32'(pause), 32'd0);
    pause_btn = 1'b0; ticks(3);

    // Dimming sequence with 7/6/3
    r_in = 3'd7; g_in = 3'd6; b_in = 2'd3;
    pause_btn = 1'b1; tick();
    ticks(10);
    chk("dim1", 32'(dim_level), 32'd1);
    tick();
    chk("dim1_r", 32'(r_out), 32'd3);
    chk("dim1_g", 32'(g_out), 32'd3);
    chk("dim1_b", 32'(b_out), 32'd1);
    ticks(3);
    chk("dim2", 32'(dim_level), 32'd2);
    tick();
    chk("dim2_r", 32'(r_out), 32'd1);
    chk("dim2_g", 32'(g_out), 32'd1);
    chk("dim2_b", 32'(b_out), 32'd0);
    ticks(10);
    chk("dim2_hold", 32'(dim_level), 32'd2);

    // Wake at dim 2
    wake = 1'b1; tick();
    chk("wake_dim", 32'(dim_level), 32'd0);
    chk("wake_up", 32'(user_paused), 32'd1);
    wake = 1'b0; ticks(9);
    chk("wake_dim_still0", 32'(dim_level), 32'd0);
    tick();
    chk("wake_redim", 32'(dim_level), 32'd1);

    // Button edge together with wake at dim 1
    pause_btn = 1'b0; tick();
    pause_btn = 1'b1; wake = 1'b1; tick();
    chk("edge_wake_up", 32'(user_paused), 32'd0);
    chk("edge_wake_pause", 32'(pause), 32'd0);
    wake = 1'b0; tick();
    chk("edge_wake_dim", 32'(dim_level), 32'd0);

    // External pause for 5 cycles, button held (no edge)
    ext_pause = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ext_pause_on", 32'(pause), 32'd1);
    end
    ext_pause = 2'b00; tick();
    chk("ext_pause_off", 32'(pause), 32'd0);
    chk("ext_dim", 32'(dim_level), 32'd0);

    // Reset at dim 2 with button held
    pause_btn = 1'b0; tick();
    pause_btn = 1'b1; ticks(15);
    chk("pre_rst_dim", 32'(dim_level), 32'd2);
    reset_n = 1'b0; tick();
    chk("rst2_pause", 32'(pause), 32'd0);
    chk("rst2_up", 32'(user_paused), 32'd0);
    chk("rst2_dim", 32'(dim_level), 32'd0);
    chk("rst2_r", 32'(r_out), 32'd0);
    reset_n = 1'b1; ticks(3);
    chk("rst2_no_toggle", 32'(user_paused), 32'd0);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) pause_btn = ~pause_btn;
      wake      = ($urandom_range(0, 29) == 0);
      ext_pause = ($urandom_range(0, 7) == 0) ? NSRC'($urandom) : '0;
      reset_n   = ($urandom_range(0, 499) != 0);
      r_in      = RW'($urandom);
      g_in      = GW'($urandom);
      b_in      = BW'($urandom);
      {hs_in, vs_in, hblank_in, vblank_in} = 4'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
